// File: rtl/tqvp_gray_sched_pkg.sv
// Shared encodings, register addresses and payload types for the gray-code
// conversion scheduler.
package tqvp_gray_sched_pkg;

  localparam int unsigned DEF_REQ_DEPTH = 4;
  localparam int unsigned DEF_RES_DEPTH = 4;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_B2G    = 4'h1;
  localparam logic [3:0] ADDR_G2B    = 4'h2;
  localparam logic [3:0] ADDR_HEAD   = 4'h3;
  localparam logic [3:0] ADDR_POP    = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h5;
  localparam logic [3:0] ADDR_FLUSH  = 4'h6;

  typedef enum logic {OP_G2B = 1'b0, OP_B2G = 1'b1} op_e;
  typedef enum logic {SRC_CPU = 1'b0, SRC_SMP = 1'b1} src_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] data;
  } req_t;

  typedef struct packed {
    src_e       src;
    logic [7:0] data;
  } res_t;

endpackage

// File: rtl/gray_conv_unit.sv
// Combinational binary<->gray converter shared by both request sources.
module gray_conv_unit
  import tqvp_gray_sched_pkg::*;
(
  input  op_e        op,
  input  logic [7:0] operand,
  output logic [7:0] result
);

  // gray->bin bit i is the XOR of all gray bits at or above i
  always_comb begin
    result = operand ^ (operand >> 1);
    if (op == OP_G2B) begin
      for (int i = 0; i < 8; i++) result[i] = ^(operand >> i);
    end
  end

endmodule

// File: rtl/tqvp_gray_conv_sched.sv
// Register-mapped scheduler arbitrating CPU requests and a prescaled ui_in
// sampler onto one shared gray converter, with a result FIFO.
module tqvp_gray_conv_sched
  import tqvp_gray_sched_pkg::*;
#(
  parameter int unsigned REQ_DEPTH = DEF_REQ_DEPTH,
  parameter int unsigned RES_DEPTH = DEF_RES_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int unsigned RQ_AW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned RQ_CW = $clog2(REQ_DEPTH + 1);
  localparam int unsigned RS_AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned RS_CW = $clog2(RES_DEPTH + 1);

  logic [7:0] ctrl;
  logic [3:0] presc;
  logic [7:0] slot;
  logic       pending, req_ovf, smp_ovr;
  src_e       last_grant;

  req_t             rq_mem [REQ_DEPTH];
  logic [RQ_AW-1:0] rq_wr, rq_rd;
  logic [RQ_CW-1:0] rq_cnt;
  res_t             rs_mem [RES_DEPTH];
  logic [RS_AW-1:0] rs_wr, rs_rd;
  logic [RS_CW-1:0] rs_cnt;

  logic wr_ctrl, wr_req, flush, rq_full, rs_empty, rs_space, tick;
  logic grant_cpu, grant_smp, push_req, pop_res;
  op_e        conv_op;
  logic [7:0] conv_in, conv_out;
  res_t       head;
  logic [7:0] status;

  always_comb begin
    wr_ctrl  = data_write && (address == ADDR_CTRL);
    wr_req   = data_write && ((address == ADDR_B2G) || (address == ADDR_G2B));
    flush    = data_write && (address == ADDR_FLUSH);
    rq_full  = (rq_cnt == RQ_CW'(REQ_DEPTH));
    rs_empty = (rs_cnt == '0);
    rs_space = (rs_cnt < RS_CW'(RES_DEPTH));
    tick     = ctrl[0] && (presc == ctrl[7:4]);
    // round-robin between the two sources; flush blocks any grant
    grant_cpu = !flush && rs_space && (rq_cnt != '0) && (!pending || last_grant == SRC_SMP);
    grant_smp = !flush && rs_space && pending && ((rq_cnt == '0) || last_grant == SRC_CPU);
    push_req  = wr_req && !rq_full && !flush;
    pop_res   = data_write && (address == ADDR_POP) && !rs_empty;
    conv_op   = grant_smp ? op_e'(ctrl[1]) : rq_mem[rq_rd].op;
    conv_in   = grant_smp ? slot : rq_mem[rq_rd].data;
    head      = rs_empty ? '0 : rs_mem[rs_rd];
    status    = {pending, smp_ovr, req_ovf, rq_full, head.src, 3'(rs_cnt)};
  end

  gray_conv_unit u_conv (
    .op      (conv_op),
    .operand (conv_in),
    .result  (conv_out)
  );

  assign uo_out = head.data;

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL:   data_out = ctrl;
      ADDR_HEAD:   data_out = head.data;
      ADDR_STATUS: data_out = status;
      default:     data_out = '0;
    endcase
  end

  // control register and prescaler
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl  <= '0;
      presc <= '0;
    end else begin
      if (wr_ctrl) ctrl <= data_in & 8'hF3;
      if (!ctrl[0] || tick) presc <= '0;
      else                  presc <= presc + 4'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_req) rq_mem[rq_wr] <= '{op: (address == ADDR_B2G) ? OP_B2G : OP_G2B, data: data_in};
    if (grant_cpu || grant_smp) rs_mem[rs_wr] <= '{src: grant_smp ? SRC_SMP : SRC_CPU, data: conv_out};
  end

  // FIFO pointers and counts
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rq_wr  <= '0;
      rq_rd  <= '0;
      rq_cnt <= '0;
      rs_wr  <= '0;
      rs_rd  <= '0;
      rs_cnt <= '0;
    end else begin
      if (push_req)  rq_wr <= (rq_wr == RQ_AW'(REQ_DEPTH - 1)) ? '0 : rq_wr + RQ_AW'(1);
      if (grant_cpu) rq_rd <= (rq_rd == RQ_AW'(REQ_DEPTH - 1)) ? '0 : rq_rd + RQ_AW'(1);
      if (push_req && !grant_cpu)      rq_cnt <= rq_cnt + RQ_CW'(1);
      else if (!push_req && grant_cpu) rq_cnt <= rq_cnt - RQ_CW'(1);
      if (grant_cpu || grant_smp) rs_wr <= (rs_wr == RS_AW'(RES_DEPTH - 1)) ? '0 : rs_wr + RS_AW'(1);
      if (pop_res)                rs_rd <= (rs_rd == RS_AW'(RES_DEPTH - 1)) ? '0 : rs_rd + RS_AW'(1);
      if ((grant_cpu || grant_smp) && !pop_res)      rs_cnt <= rs_cnt + RS_CW'(1);
      else if (!(grant_cpu || grant_smp) && pop_res) rs_cnt <= rs_cnt - RS_CW'(1);
    end
  end

  // sample slot, sticky flags and arbitration history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot       <= '0;
      pending    <= 1'b0;
      req_ovf    <= 1'b0;
      smp_ovr    <= 1'b0;
      last_grant <= SRC_SMP;
    end else if (flush) begin
      pending <= 1'b0;
      req_ovf <= 1'b0;
      smp_ovr <= 1'b0;
    end else begin
      if (wr_req && rq_full) req_ovf <= 1'b1;
      if (tick) begin
        slot    <= ui_in;
        pending <= 1'b1;
        if (pending && !grant_smp) smp_ovr <= 1'b1;
      end else if (grant_smp) begin
        pending <= 1'b0;
      end
      if (grant_cpu)      last_grant <= SRC_CPU;
      else if (grant_smp) last_grant <= SRC_SMP;
    end
  end

endmodule

// File: tb/tb_tqvp_gray_conv_sched.sv
// Directed bench: stimulus queues expected results, a monitor checks each pop.
module tb_tqvp_gray_conv_sched;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  tqvp_gray_conv_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    step();
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string name);
    address = a;
    #1;
    chk(name, data_out, e);
  endtask

  task automatic push_b2g(input logic [7:0] d, input logic [7:0] e, input bit track);
    if (track) exp_q.push_back(e);
    wr(4'h1, d);
  endtask

  // monitor: every pop of the result FIFO must present the oldest expected result
  always @(negedge clk) begin
    if (rst_n && data_write && address == 4'h4) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        chk("pop_data", uo_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] v1 [5];
    logic [7:0] e1 [5];
    logic [7:0] v2 [5];
    logic [7:0] e2 [5];
    v1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    e1 = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};
    v2 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    e2 = '{8'h18, 8'h19, 8'h1B, 8'h1A, 8'h1E};

    rst_n = 1'b0; data_write = 1'b0; address = '0; data_in = '0; ui_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, "reset_rd");
    chk("reset_uo", uo_out, 0);

    // single bin->gray request, two-edge latency
    push_b2g(8'h5A, 8'h77, 1'b1);
    step();
    rd(4'h3, 8'h77, "b2g_head");
    rd(4'h5, 8'h01, "b2g_status");
    wr(4'h4, 8'h00);
    rd(4'h5, 8'h00, "b2g_status_empty");

    // two gray->bin requests kept in order
    exp_q.push_back(8'h5A);
    wr(4'h2, 8'h77);
    exp_q.push_back(8'hAA);
    wr(4'h2, 8'hFF);
    step();
    rd(4'h5, 8'h02, "g2b_status");
    wr(4'h4, 8'h00);
    wr(4'h4, 8'h00);
    rd(4'h3, 8'h00, "g2b_head_empty");

    // result FIFO fill, queued fifth request, then request overflow
    for (int i = 0; i < 5; i++) push_b2g(v1[i], e1[i], 1'b1);
    rd(4'h5, 8'h04, "fill_status");
    wr(4'h4, 8'h00);
    step();
    rd(4'h5, 8'h04, "fifth_no_ovf");
    for (int i = 0; i < 5; i++) push_b2g(v2[i], e2[i], i < 4);
    rd(4'h5, 8'h34, "req_ovf_status");
    for (int i = 0; i < 8; i++) wr(4'h4, 8'h00);
    rd(4'h5, 8'h20, "ovf_sticky");
    wr(4'h6, 8'h00);
    rd(4'h5, 8'h00, "flush_clears_ovf");

    // sampler overrun with full result FIFO, then flush
    for (int i = 0; i < 4; i++) push_b2g(v1[i], e1[i], 1'b0);
    wr(4'h0, 8'h01);
    step();
    step();
    rd(4'h5, 8'hC4, "smp_ovr_status");
    wr(4'h0, 8'h00);
    wr(4'h6, 8'h00);
    rd(4'h5, 8'h00, "smp_flush_status");
    rd(4'h0, 8'h00, "ctrl_cleared");

    // reset with both FIFOs partly occupied
    wr(4'h0, 8'hF3);
    rd(4'h0, 8'hF3, "ctrl_readback");
    for (int i = 0; i < 5; i++) push_b2g(v2[i], e2[i], 1'b0);
    push_b2g(8'h20, 8'h30, 1'b0);
    rd(4'h5, 8'h04, "pre_reset_status");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, "midreset_rd");
    chk("midreset_uo", uo_out, 0);
    repeat (3) step();
    rd(4'h5, 8'h00, "midreset_no_results");

    // CPU/sampler alternation, CPU first after reset
    ui_in = 8'hFF;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hAA);
    wr(4'h0, 8'h01);
    wr(4'h1, 8'hFF);
    wr(4'h1, 8'hFF);
    repeat (3) step();
    wr(4'h0, 8'h00);
    rd(4'h5, 8'hC4, "alt_status_cpu_head");
    wr(4'h4, 8'h00);
    rd(4'h5, 8'hCB, "alt_status_smp_head");
    for (int i = 0; i < 4; i++) wr(4'h4, 8'h00);
    rd(4'h5, 8'h40, "alt_drained");

    // prescale P=1: sample every second cycle
    wr(4'h6, 8'h00);
    rd(4'h5, 8'h00, "presc_flush");
    ui_in = 8'h03;
    exp_q.push_back(8'h02);
    wr(4'h0, 8'h11);
    step();
    rd(4'h5, 8'h00, "presc_wait");
    step();
    rd(4'h5, 8'h80, "presc_tick");
    wr(4'h0, 8'h00);
    rd(4'h5, 8'h09, "presc_result");
    wr(4'h4, 8'h00);
    rd(4'h5, 8'h00, "presc_empty");

    step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
